// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with redirect/squash toward decode.
// Optional misaligned-redirect trap: define IFETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_err_o
);
  typedef enum logic [2:0] {ST_RESET, ST_REQ, ST_WAIT, ST_HOLD, ST_DROP} state_t;
  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc, r_instr, w_instr, r_ipc, w_ipc, w_tgt;
  logic        r_valid, w_valid, r_err, w_err, w_mis, w_pend;
`ifdef IFETCH_MISALIGN_TRAP_EN
  assign w_tgt = redirect_pc_i;
  assign w_mis = |redirect_pc_i[1:0];
`else
  assign w_tgt = redirect_pc_i & 32'hFFFF_FFFC;
  assign w_mis = 1'b0;
`endif
  // A response is still owed by memory after this cycle
  assign w_pend = (r_state == ST_REQ && mem_gnt_i) ||
                  ((r_state == ST_WAIT || r_state == ST_DROP) && !mem_rvalid_i);
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_instr = r_instr;
    w_ipc   = r_ipc;
    w_valid = r_valid;
    w_err   = r_err;
    case (r_state)
      ST_RESET: w_state = ST_REQ;
      ST_REQ:   w_state = mem_gnt_i ? ST_WAIT : ST_REQ;
      ST_WAIT: if (mem_rvalid_i) begin
        w_instr = mem_rdata_i;
        w_ipc   = r_pc;
        w_valid = 1'b1;
        w_pc    = r_pc + 32'd4;
        w_state = ST_HOLD;
      end
      ST_HOLD: if (instr_ready_i && r_valid) begin
        w_valid = 1'b0;
        w_state = ST_REQ;
      end
      ST_DROP: if (mem_rvalid_i) w_state = r_err ? ST_HOLD : ST_REQ;
      default: w_state = ST_RESET;
    endcase
    // Redirect overrides everything, including a response landing this cycle
    if (redirect_i) begin
      w_pc    = w_tgt;
      w_instr = r_instr;
      w_ipc   = r_ipc;
      w_valid = 1'b0;
      w_err   = w_mis;
      w_state = w_pend ? ST_DROP : (w_mis ? ST_HOLD : ST_REQ);
    end
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_RESET;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0000_0013;
      r_ipc   <= RESET_PC;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_instr <= w_instr;
      r_ipc   <= w_ipc;
      r_valid <= w_valid;
      r_err   <= w_err;
    end
  end
  assign mem_req_o     = (r_state == ST_REQ);
  assign mem_addr_o    = r_pc;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_ipc;
  assign fetch_err_o   = r_err;
endmodule
